// File: rtl/pipe_mux.sv
// pipe_mux: registered N:1 channel multiplexer with a two-entry skid buffer.
//
// An accepted item is the in_data channel picked by sel. If sel does not name
// a real channel, the item is all zeros and the sticky sel_err flag is raised.
// Items go into a main register, which drives out_data/out_valid. A single
// skid register takes the next item while the main register stalls, so
// in_ready is simply "skid empty". This makes in_ready come straight from a
// flop, with no combinational path from in_valid or out_ready.
//
// Parameters
//   DATA_WIDTH  width of each data channel
//   NUM_INPUTS  number of channels (2..16)
//   SEL_WIDTH   select width, must be ceil(log2(NUM_INPUTS))
//   CNT_WIDTH   width of the wrapping transfer counter
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; clears both stored items at once
//   in_data    packed channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel        channel select, sampled together with in_valid
//   in_valid   upstream offers an item
//   in_ready   block can accept an item (skid register empty)
//   out_data   selected data held in the main register
//   out_valid  out_data holds an item that has not been consumed yet
//   out_ready  downstream accepts the item
//   sel_err    sticky flag: an item with an out-of-range select was accepted
//   err_clr    synchronous clear of sel_err (a new error on the same edge wins)
//   xfer_cnt   count of completed output transfers, wraps to zero

module pipe_mux #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             sel_err,
    input  logic                             err_clr,
    output logic [CNT_WIDTH-1:0]             xfer_cnt
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] item;
    logic                  sel_hit;
    logic                  accept;
    logic                  drain;

    // sel_hit stays low when sel names no real channel. The item then stays
    // zero and the error flag can be set, without indexing past in_data.
    always_comb begin
        item    = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                item    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_hit = 1'b1;
            end
        end
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign drain    = out_valid & out_ready;

    // The skid register is only ever full while the main register is full.
    // When the main register is empty, the new item can therefore go straight
    // into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid) begin
            if (accept) begin
                out_data  <= item;
                out_valid <= 1'b1;
            end
        end else if (out_ready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data <= item;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= item;
            skid_valid <= 1'b1;
        end
    end

    // When a new bad select and err_clr arrive on the same edge, the set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_hit) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (drain) begin
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux with 3 channels of 32 bits, a 2-bit select (so sel=3 is
// out of range) and a 4-bit counter (so counter wrap happens quickly).
// The reference model is a plain queue of at most two items.
module tb_pipe_mux;

    localparam int DW = 32;
    localparam int NI = 3;
    localparam int SW = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NI*DW-1:0]  in_data = '0;
    logic [SW-1:0]     sel = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              sel_err;
    logic              err_clr = 1'b0;
    logic [CW-1:0]     xfer_cnt;

    int checks = 0;
    int errors = 0;

    pipe_mux #(
        .DATA_WIDTH(DW),
        .NUM_INPUTS(NI),
        .SEL_WIDTH (SW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .err_clr  (err_clr),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];
    logic          m_err = 1'b0;
    int            m_cnt = 0;

    function automatic logic [DW-1:0] pick(input logic [NI*DW-1:0] d, input logic [SW-1:0] s);
        if (int'(s) < NI) return d[int'(s)*DW +: DW];
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            bit acc;
            bit xfr;
            acc = in_valid && (mq.size() < 2);
            xfr = (mq.size() > 0) && out_ready;
            if (xfr) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (acc) mq.push_back(pick(in_data, sel));
            if (acc && int'(sel) >= NI) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs on every falling edge, while the DUT outputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(1));
            chk("rst_out_data", 64'(out_data), 64'(0));
            chk("rst_sel_err", 64'(sel_err), 64'(0));
            chk("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        end else begin
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
            if (mq.size() > 0) chk("m_out_data", 64'(out_data), 64'(mq[0]));
            chk("m_sel_err", 64'(sel_err), 64'(m_err));
            chk("m_xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [SW-1:0] s, input bit rdy, input bit clr);
        @(negedge clk);
        in_valid  = v;
        sel       = s;
        out_ready = rdy;
        err_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        chk("arst_out_data", 64'(out_data), 64'(0));
        chk("arst_sel_err", 64'(sel_err), 64'(0));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_xfer_cnt", 64'(xfer_cnt), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Select channel 2 with the output always ready.
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        drive(1, 2, 1, 0);
        tick();
        chk("sel2_data", 64'(out_data), 64'h33333333);
        chk("sel2_valid", 64'(out_valid), 64'(1));
        chk("sel2_cnt0", 64'(xfer_cnt), 64'(0));
        drive(0, 0, 1, 0);
        tick();
        chk("sel2_cnt1", 64'(xfer_cnt), 64'(1));
        chk("sel2_empty", 64'(out_valid), 64'(0));

        // Stall: A is held in main, B goes to skid, then both drain in order.
        in_data = {32'h0000cccc, 32'h0000bbbb, 32'h0000aaaa};
        drive(1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        tick();
        chk("stall_hold_a", 64'(out_data), 64'h0000aaaa);
        chk("stall_not_ready", 64'(in_ready), 64'(0));
        drive(1, 2, 0, 0);
        tick();
        chk("stall_still_a", 64'(out_data), 64'h0000aaaa);
        drive(0, 0, 1, 0);
        tick();
        chk("drain_b", 64'(out_data), 64'h0000bbbb);
        chk("drain_ready", 64'(in_ready), 64'(1));
        chk("drain_cnt2", 64'(xfer_cnt), 64'(2));
        drive(0, 0, 1, 0);
        tick();
        chk("drain_empty", 64'(out_valid), 64'(0));
        chk("drain_cnt3", 64'(xfer_cnt), 64'(3));

        // Out-of-range select: zero data, sticky error, set beats clear.
        drive(1, 3, 1, 0);
        tick();
        chk("bad_sel_data", 64'(out_data), 64'(0));
        chk("bad_sel_err", 64'(sel_err), 64'(1));
        drive(1, 3, 1, 1);
        tick();
        chk("set_wins_clr", 64'(sel_err), 64'(1));
        drive(0, 0, 1, 1);
        tick();
        chk("err_cleared", 64'(sel_err), 64'(0));
        drive(0, 0, 1, 0);
        tick();

        // Two items stored, then reset asserted between clock edges.
        drive(1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        tick();
        chk("full_not_ready", 64'(in_ready), 64'(0));
        pulse_reset();

        // Stream of 100 items: counter wraps modulo 16 to 100 % 16 = 4.
        for (int i = 0; i < 100; i++) begin
            drive(1, SW'($urandom_range(0, 2)), 1, 0);
            in_data = {$urandom, $urandom, $urandom};
            tick();
            chk("stream_ready", 64'(in_ready), 64'(1));
        end
        drive(0, 0, 1, 0);
        tick();
        chk("stream_cnt", 64'(xfer_cnt), 64'(4));

        // Wrap: 17 transfers after reset leave the count at 1.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 1, 0);
            in_data = {$urandom, $urandom, $urandom};
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        chk("wrap_cnt", 64'(xfer_cnt), 64'(1));

        // Random traffic with back-pressure, bad selects and clears.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, SW'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
            in_data = {$urandom, $urandom, $urandom};
            if (i == 700) pulse_reset();
        end
        drive(0, 0, 1, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of each data channel.
REQ-002 Parameter NUM_INPUTS, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_WIDTH, default 2, select width; SHALL equal ceil(log2(NUM_INPUTS)).
REQ-004 Parameter CNT_WIDTH, default 16, width of transfer counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 in_data  input  NUM_INPUTS*DATA_WIDTH  packed channels; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 sel  input  SEL_WIDTH  channel select, sampled with in_valid.
REQ-009 in_valid  input  1  upstream offers in_data/sel.
REQ-010 in_ready  output  1  block can accept; SHALL equal NOT skid_full (register-driven, no combinational path from in_valid/out_ready).
REQ-011 out_data  output  DATA_WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed item.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 sel_err  output  1  sticky flag, out-of-range select accepted.
REQ-015 err_clr  input  1  synchronous clear of sel_err.
REQ-016 xfer_cnt  output  CNT_WIDTH  count of completed output transfers.

Function
REQ-017 Accept event = in_valid AND in_ready at a rising edge; output transfer = out_valid AND out_ready at a rising edge.
REQ-018 Storage: main register (drives out_data/out_valid) plus one skid register; total capacity 2 items.
REQ-019 Accepted item = in_data channel sel; if sel >= NUM_INPUTS, item = all zeros.
REQ-020 Latency: item accepted at edge k SHALL appear on out_data with out_valid=1 after edge k when main is empty or being drained that edge with skid empty.
REQ-021 Edge update, main empty: accept -> main loads item.
REQ-022 Main full, out_ready=1, skid full: main loads skid, skid empties (no accept possible since in_ready=0).
REQ-023 Main full, out_ready=1, skid empty: main loads accepted item if accept, else main empties.
REQ-024 Main full, out_ready=0, accept: skid loads item; main holds.
REQ-025 Main full, out_ready=0, no accept: all state holds; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Order SHALL be preserved; no item dropped or duplicated.
REQ-027 sel_err sets on any accept with sel >= NUM_INPUTS; clears on err_clr=1 at edge; simultaneous set and clear -> set wins.
REQ-028 xfer_cnt increments by 1 per output transfer, wraps from 2^CNT_WIDTH-1 to 0.
REQ-029 No #delay constructs; timing purely edge-based.

Reset
REQ-030 While rst_n=0 (asynchronous): out_valid=0, out_data=0, skid empty (in_ready=1), sel_err=0, xfer_cnt=0.
REQ-031 Reset asserted mid-operation SHALL discard both stored items immediately, without waiting for a clock edge.
REQ-032 First accept possible on first rising edge with rst_n=1.

Verification
REQ-033 NUM_INPUTS=4: in_data channels 0x11..,0x22..,0x33..,0x44.., sel=2, in_valid=1, out_ready=1 -> next cycle out_data=0x33.., out_valid=1, xfer_cnt increments following edge.
REQ-034 out_ready=0, accept A then B -> out_data=A held, in_ready=0 after B; raise out_ready -> A, then B transferred in order, in_ready returns 1.
REQ-035 Back-to-back stream 100 items, out_ready=1 constant -> 1 item/cycle, in_ready never drops, xfer_cnt=100.
REQ-036 NUM_INPUTS=3, sel=3 accepted -> out_data=0, sel_err=1 held; err_clr=1 with new bad sel same edge -> sel_err stays 1; err_clr alone -> 0.
REQ-037 Two items stored, rst_n pulsed low between edges -> out_valid=0, in_ready=1, xfer_cnt=0 immediately.
REQ-038 CNT_WIDTH=4, 17 transfers -> xfer_cnt=1 (wrap verified).
